bp_be_rpush_issue: RTL and testbench
====================================

# bp_be_rpush_issue

Issue-side controller for remote register pushes (rpush) in the multi-threaded backend. It accepts rpush commands decoded from CSR 0x083 writes, checks the target thread, and buffers accepted commands in a small queue. It then drives the regfile's dedicated rpush write bus, but only in cycles with no normal writeback. Normal writeback and rpush therefore never collide at the regfile.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg: supplies thread_id_width_p and num_threads_p (2**thread_id_width_p)
- data_width_p, none (required): register data width, 64 for RV64
- fifo_els_p, 2: command queue depth, at least 2

Ports:
- clk_i  in  1  clock; one clock domain only
- reset_i  in  1  synchronous, active-high reset
- cmd_v_i  in  1  command valid (CSR 0x083 write retiring)
- cmd_ready_o  out  1  queue can accept; transfer occurs on cmd_v_i & cmd_ready_o
- cmd_sel_i  in  reg_addr_width_gp+thread_id_width_p  {reg_addr, thread_id}, thread_id in the LSBs
- cmd_data_i  in  data_width_p  value to push
- self_thread_id_i  in  thread_id_width_p  thread issuing the CSR write
- thread_en_i  in  num_threads_p  per-thread enabled mask
- wb_v_i  in  1  normal writeback to the regfile this cycle
- rpush_w_v_o  out  1  rpush write strobe
- rpush_thread_id_o  out  thread_id_width_p  destination thread
- rpush_addr_o  out  reg_addr_width_gp  destination register
- rpush_data_o  out  data_width_p  write data
- err_v_o  out  1  one-cycle pulse: a command was rejected at accept
- busy_o  out  1  queue non-empty

## Operation
- Accept: on cmd_v_i & cmd_ready_o, split cmd_sel_i into thread_id = cmd_sel_i[thread_id_width_p-1:0] and reg_addr = the upper bits.
- Drop to x0: a command with reg_addr == 0 is accepted, is not enqueued, and does not raise err_v_o.
- Target check (see Configuration): a rejected command is accepted, not enqueued, and err_v_o pulses in the following cycle.
- Enqueue: every other accepted command goes into the FIFO (thread_id, reg_addr, data) in order.
- cmd_ready_o = ~full, computed from registered state. It does not depend on a same-cycle dequeue.
- FSM for the queue head:
  - e_idle: queue empty. Go to e_issue when the queue holds at least 1 entry at the clock edge.
  - e_issue: head valid. When ~wb_v_i, assert rpush_w_v_o with the head fields and dequeue. Return to e_idle if this empties the queue, otherwise stay. When wb_v_i, hold the head with no strobe (stall).
- rpush_w_v_o = (state == e_issue) & ~wb_v_i. This is the only combinational path from input to output.
- When rpush_w_v_o is low, rpush_thread_id_o, rpush_addr_o and rpush_data_o show the head entry, or zero when the queue is empty.
- Ordering: strict FIFO. Two pushes to the same register land in acceptance order.
- Simultaneous accept and issue when not full: both occur in the same cycle. Occupancy stays the same.
- A stall of any length loses no command.

## Timing
- Reset: cmd_ready_o=1, rpush_w_v_o=0, err_v_o=0, busy_o=0, rpush_*_o=0, FSM in e_idle, queue empty.
- Reset asserted mid-operation: all queued commands are discarded. Reset values apply in the next cycle.
- Latency: a command accepted in cycle N appears on rpush_w_v_o no earlier than cycle N+1, and exactly at N+1 when the queue was empty and wb_v_i=0.
- Back-to-back: with wb_v_i held low, the unit sustains one rpush per cycle.
- busy_o is registered: it rises the cycle after the first enqueue and falls the cycle after the last dequeue.
- err_v_o is registered: a one-cycle pulse at N+1 for a rejection at N.

## Configuration
- Macro BP_BE_RPUSH_TARGET_CHECK_EN.
- Defined: reject a command when thread_en_i[thread_id]==1 (target running) or thread_id == self_thread_id_i.
- Not defined: no target check. Every command to a non-x0 register is enqueued, and err_v_o is tied to 0.

## Test plan
- Basic push: reset; wb_v_i=0; thread_en_i=4'b0001, self=0; cmd_sel={5'd7,2'd2}, data=0xDEADBEEF -> next cycle rpush_w_v_o=1, thread 2, addr 7, data 0xDEADBEEF; busy_o then falls.
- Writeback stall: queue 2 commands (x5→T1, x6→T1); hold wb_v_i=1 for 3 cycles -> no strobe and cmd_ready_o=0 while full. Release -> x5, then x6, on two consecutive cycles.
- Rejection with macro defined: target thread 0 while thread_en_i[0]=1 -> err_v_o pulses one cycle and no rpush. Self-target (thread_id=self=3) -> same result.
- Rejection with macro undefined: same stimulus -> rpush to T0 issues and err_v_o stays 0.
- x0 drop: cmd_sel={5'd0,2'd1} -> no rpush, no err_v_o, busy_o stays 0.
- Reset mid-operation: 2 queued, wb_v_i=1, assert reset for 1 cycle -> no rpush afterwards, cmd_ready_o=1, busy_o=0.

Source files
------------

// File: rtl/bp_be_rpush_issue.sv
// Issue-side rpush controller: accepts CSR 0x083 push commands, queues them,
// and drives the regfile rpush bus only in cycles without normal writeback.
// Optional target-thread check enabled by defining BP_BE_RPUSH_TARGET_CHECK_EN.
module bp_be_rpush_issue #(
    parameter int thread_id_width_p = 2,
    parameter int num_threads_p     = 2**thread_id_width_p,
    parameter int reg_addr_width_gp = 5,
    parameter int data_width_p      = 64,
    parameter int fifo_els_p        = 2
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       cmd_v_i,
    output logic                                       cmd_ready_o,
    input  logic [reg_addr_width_gp+thread_id_width_p-1:0] cmd_sel_i,
    input  logic [data_width_p-1:0]                    cmd_data_i,
    input  logic [thread_id_width_p-1:0]               self_thread_id_i,
    input  logic [num_threads_p-1:0]                   thread_en_i,
    input  logic                                       wb_v_i,
    output logic                                       rpush_w_v_o,
    output logic [thread_id_width_p-1:0]               rpush_thread_id_o,
    output logic [reg_addr_width_gp-1:0]               rpush_addr_o,
    output logic [data_width_p-1:0]                    rpush_data_o,
    output logic                                       err_v_o,
    output logic                                       busy_o
);

    localparam int PTR_W = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int CNT_W = $clog2(fifo_els_p + 1);

    typedef enum logic {e_idle, e_issue} state_e;

    state_e                          r_state;
    logic [thread_id_width_p-1:0]    r_tid  [fifo_els_p];
    logic [reg_addr_width_gp-1:0]    r_addr [fifo_els_p];
    logic [data_width_p-1:0]         r_data [fifo_els_p];
    logic [PTR_W-1:0]                r_rd_ptr;
    logic [PTR_W-1:0]                r_wr_ptr;
    logic [CNT_W-1:0]                r_count;
    logic                            r_busy;
    logic                            r_err;

    logic [thread_id_width_p-1:0]    w_tid;
    logic [reg_addr_width_gp-1:0]    w_addr;
    logic                            w_accept;
    logic                            w_reject;
    logic                            w_enq;
    logic                            w_deq;
    logic                            w_head_v;
    logic [CNT_W-1:0]                w_count_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_tid    = cmd_sel_i[thread_id_width_p-1:0];
    assign w_addr   = cmd_sel_i[thread_id_width_p +: reg_addr_width_gp];
    assign w_accept = cmd_v_i & cmd_ready_o;

`ifdef BP_BE_RPUSH_TARGET_CHECK_EN
    // Only idle, foreign threads may receive a push.
    assign w_reject = thread_en_i[w_tid] | (w_tid == self_thread_id_i);
`else
    logic w_unused;
    assign w_unused = ^{self_thread_id_i, thread_en_i};
    assign w_reject = 1'b0;
`endif

    // x0 writes are swallowed silently before the target check applies.
    assign w_enq        = w_accept & (w_addr != '0) & ~w_reject;
    assign w_deq        = rpush_w_v_o;
    assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    assign w_head_v     = (r_count != '0);

    assign cmd_ready_o       = (r_count != CNT_W'(fifo_els_p));
    assign rpush_w_v_o       = (r_state == e_issue) & ~wb_v_i;
    assign rpush_thread_id_o = w_head_v ? r_tid[r_rd_ptr]  : '0;
    assign rpush_addr_o      = w_head_v ? r_addr[r_rd_ptr] : '0;
    assign rpush_data_o      = w_head_v ? r_data[r_rd_ptr] : '0;
    assign err_v_o           = r_err;
    assign busy_o            = r_busy;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_tid[r_wr_ptr]  <= w_tid;
            r_addr[r_wr_ptr] <= w_addr;
            r_data[r_wr_ptr] <= cmd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= e_idle;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_enq) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_deq) r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= w_count_next;
            r_busy  <= (w_count_next != '0);
            r_err   <= w_accept & (w_addr != '0) & w_reject;
            case (r_state)
                e_idle:  if (w_count_next != '0) r_state <= e_issue;
                e_issue: if (w_count_next == '0) r_state <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_rpush_issue.sv
// Bench for bp_be_rpush_issue: directed vector table, rejection/streaming
// sequences, and randomized traffic against a queue-based reference model.
module tb_bp_be_rpush_issue;

    localparam int TW = 2, AW = 5, DW = 64, DEPTH = 2, NT = 4;

`ifdef BP_BE_RPUSH_TARGET_CHECK_EN
    localparam bit REJ_ON = 1'b1;
`else
    localparam bit REJ_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_i;
    logic              cmd_v_i;
    logic              cmd_ready_o;
    logic [AW+TW-1:0]  cmd_sel_i;
    logic [DW-1:0]     cmd_data_i;
    logic [TW-1:0]     self_thread_id_i;
    logic [NT-1:0]     thread_en_i;
    logic              wb_v_i;
    logic              rpush_w_v_o;
    logic [TW-1:0]     rpush_thread_id_o;
    logic [AW-1:0]     rpush_addr_o;
    logic [DW-1:0]     rpush_data_o;
    logic              err_v_o;
    logic              busy_o;

    always #5 clk = ~clk;

    bp_be_rpush_issue #(
        .thread_id_width_p (TW),
        .num_threads_p     (NT),
        .reg_addr_width_gp (AW),
        .data_width_p      (DW),
        .fifo_els_p        (DEPTH)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .cmd_v_i           (cmd_v_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_sel_i         (cmd_sel_i),
        .cmd_data_i        (cmd_data_i),
        .self_thread_id_i  (self_thread_id_i),
        .thread_en_i       (thread_en_i),
        .wb_v_i            (wb_v_i),
        .rpush_w_v_o       (rpush_w_v_o),
        .rpush_thread_id_o (rpush_thread_id_o),
        .rpush_addr_o      (rpush_addr_o),
        .rpush_data_o      (rpush_data_o),
        .err_v_o           (err_v_o),
        .busy_o            (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending pushes held as a plain queue.
    typedef struct { bit [TW-1:0] tid; bit [AW-1:0] addr; bit [DW-1:0] data; } ent_t;
    ent_t mq[$];
    bit   m_err  = 1'b0;
    bit   m_busy = 1'b0;

    function automatic bit rejected(input bit [TW-1:0] tid, input bit [TW-1:0] self,
                                    input bit [NT-1:0] en);
        return REJ_ON && (en[tid] || tid == self);
    endfunction

    task automatic check_model(input string tag);
        ent_t h;
        h.tid = '0; h.addr = '0; h.data = '0;
        if (mq.size() > 0) h = mq[0];
        chk({tag, ".ready"},  cmd_ready_o, 64'(mq.size() < DEPTH));
        chk({tag, ".strobe"}, rpush_w_v_o, 64'(mq.size() > 0 && !wb_v_i));
        chk({tag, ".tid"},    rpush_thread_id_o, 64'(h.tid));
        chk({tag, ".addr"},   rpush_addr_o, 64'(h.addr));
        chk({tag, ".data"},   rpush_data_o, h.data);
        chk({tag, ".err"},    err_v_o, 64'(m_err));
        chk({tag, ".busy"},   busy_o, 64'(m_busy));
    endtask

    task automatic model_update();
        bit acc, pop, rej;
        bit [TW-1:0] tid;
        bit [AW-1:0] addr;
        ent_t e;
        acc  = cmd_v_i && (mq.size() < DEPTH);
        pop  = (mq.size() > 0) && !wb_v_i;
        tid  = cmd_sel_i[TW-1:0];
        addr = cmd_sel_i[AW+TW-1:TW];
        rej  = rejected(tid, self_thread_id_i, thread_en_i);
        if (reset_i) begin
            mq.delete();
            m_err  = 1'b0;
            m_busy = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc && addr != 0 && !rej) begin
                e.tid = tid; e.addr = addr; e.data = cmd_data_i;
                mq.push_back(e);
            end
            m_err  = acc && addr != 0 && rej;
            m_busy = mq.size() != 0;
        end
    endtask

    task automatic drive(input bit rst, input bit cv, input bit [AW+TW-1:0] sel,
                         input bit [DW-1:0] d, input bit [TW-1:0] self,
                         input bit [NT-1:0] en, input bit wb);
        reset_i = rst; cmd_v_i = cv; cmd_sel_i = sel; cmd_data_i = d;
        self_thread_id_i = self; thread_en_i = en; wb_v_i = wb;
    endtask

    task automatic cycle(input bit use_model, input string tag);
        @(negedge clk);
        if (use_model) check_model(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst, cv; bit [AW+TW-1:0] sel; bit [DW-1:0] d; bit [TW-1:0] self;
        bit [NT-1:0] en; bit wb;
        bit e_ready, e_strobe; bit [TW-1:0] e_tid; bit [AW-1:0] e_addr;
        bit [DW-1:0] e_data; bit e_err, e_busy;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit cv, input bit [AW+TW-1:0] sel,
                                input bit [DW-1:0] d, input bit [NT-1:0] en, input bit wb,
                                input bit rdy, input bit stb, input bit [TW-1:0] t,
                                input bit [AW-1:0] a, input bit [DW-1:0] ed,
                                input bit er, input bit bz);
        vec_t v;
        v.rst = rst; v.cv = cv; v.sel = sel; v.d = d; v.self = 2'd0; v.en = en; v.wb = wb;
        v.e_ready = rdy; v.e_strobe = stb; v.e_tid = t; v.e_addr = a;
        v.e_data = ed; v.e_err = er; v.e_busy = bz;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        // Expected outputs are those visible before the edge of the same row.
        tbl[0]  = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[1]  = mk(0,1,{5'd7,2'd2}, 64'hDEADBEEF, 4'b0001,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[2]  = mk(0,0,7'd0,        64'h0,        4'b0001,0, 1,1,2'd2,5'd7,64'hDEADBEEF, 0,1);
        tbl[3]  = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[4]  = mk(0,1,{5'd5,2'd1}, 64'h55,       4'b0000,1, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[5]  = mk(0,1,{5'd6,2'd1}, 64'h66,       4'b0000,1, 1,0,2'd1,5'd5,64'h55,       0,1);
        tbl[6]  = mk(0,0,7'd0,        64'h0,        4'b0000,1, 0,0,2'd1,5'd5,64'h55,       0,1);
        tbl[7]  = mk(0,1,{5'd9,2'd1}, 64'h99,       4'b0000,1, 0,0,2'd1,5'd5,64'h55,       0,1);
        tbl[8]  = mk(0,0,7'd0,        64'h0,        4'b0000,0, 0,1,2'd1,5'd5,64'h55,       0,1);
        tbl[9]  = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,1,2'd1,5'd6,64'h66,       0,1);
        tbl[10] = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[11] = mk(0,1,{5'd0,2'd1}, 64'h77,       4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[12] = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[13] = mk(0,1,{5'd3,2'd2}, 64'h33,       4'b0000,1, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[14] = mk(0,1,{5'd4,2'd3}, 64'h44,       4'b0000,1, 1,0,2'd2,5'd3,64'h33,       0,1);
        tbl[15] = mk(1,0,7'd0,        64'h0,        4'b0000,1, 0,0,2'd2,5'd3,64'h33,       0,1);
        tbl[16] = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);
        tbl[17] = mk(0,0,7'd0,        64'h0,        4'b0000,0, 1,0,2'd0,5'd0,64'h0,        0,0);

        drive(1, 0, '0, '0, '0, '0, 0);
        cycle(0, "rst");
        cycle(0, "rst");

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("tbl%0d", i);
            drive(tbl[i].rst, tbl[i].cv, tbl[i].sel, tbl[i].d, tbl[i].self, tbl[i].en, tbl[i].wb);
            @(negedge clk);
            chk({t, ".ready"},  cmd_ready_o,       64'(tbl[i].e_ready));
            chk({t, ".strobe"}, rpush_w_v_o,       64'(tbl[i].e_strobe));
            chk({t, ".tid"},    rpush_thread_id_o, 64'(tbl[i].e_tid));
            chk({t, ".addr"},   rpush_addr_o,      64'(tbl[i].e_addr));
            chk({t, ".data"},   rpush_data_o,      tbl[i].e_data);
            chk({t, ".err"},    err_v_o,           64'(tbl[i].e_err));
            chk({t, ".busy"},   busy_o,            64'(tbl[i].e_busy));
            model_update();
            @(posedge clk);
            #1;
        end

        // Running target, then self target: rejected only with the check built in.
        drive(0, 1, {5'd8, 2'd0}, 64'hA0, 2'd0, 4'b0001, 0);
        cycle(1, "rej_run.cmd");
        drive(0, 0, '0, '0, 2'd0, 4'b0001, 0);
        @(negedge clk);
        chk("rej_run.err", err_v_o, 64'(REJ_ON));
        chk("rej_run.strobe", rpush_w_v_o, 64'(!REJ_ON));
        model_update();
        @(posedge clk); #1;
        cycle(1, "rej_run.after");

        drive(0, 1, {5'd9, 2'd3}, 64'hB0, 2'd3, 4'b0000, 0);
        cycle(1, "rej_self.cmd");
        drive(0, 0, '0, '0, 2'd3, 4'b0000, 0);
        @(negedge clk);
        chk("rej_self.err", err_v_o, 64'(REJ_ON));
        chk("rej_self.strobe", rpush_w_v_o, 64'(!REJ_ON));
        model_update();
        @(posedge clk); #1;
        cycle(1, "rej_self.after");

        // Back-to-back stream with writeback idle: one push per cycle.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, {5'(k + 1), 2'(k)}, 64'(k * 17 + 3), 2'd0, 4'b0000, 0);
            cycle(1, $sformatf("stream%0d", k));
        end
        drive(0, 0, '0, '0, 2'd0, 4'b0000, 0);
        cycle(1, "stream.drain0");
        cycle(1, "stream.drain1");

        for (int n = 0; n < 3000; n++) begin
            bit [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 6),
                  {a, 2'($urandom)},
                  {$urandom, $urandom},
                  2'($urandom),
                  4'($urandom),
                  ($urandom_range(0, 9) < 3));
            cycle(1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
